umi_merger: RTL and testbench
=============================

// Module: umi_merger
// PURPOSE
//  Joins a UMI response stream and a UMI request stream into one UMI output stream;
//  the inverse of umi_splitter. Round-robin arbitration at message granularity: a grant
//  is held from first beat until the beat with EOM set, so multi-beat messages never interleave.
//  Sits at a port's egress, ahead of the UMI-to-queue bridge.
// PARAMETERS
//  DW  256  UMI data width (bits)
//  AW  64   UMI address width (bits)
//  CW  32   UMI command width (bits)
// PORTS
//  clk                 in   1   single clock, all logic on rising edge
//  rst                 in   1   synchronous reset, active-high
//  umi_resp_in_valid   in   1   response input valid
//  umi_resp_in_cmd     in   CW  response command
//  umi_resp_in_dstaddr in   AW  response destination address
//  umi_resp_in_srcaddr in   AW  response source address
//  umi_resp_in_data    in   DW  response data
//  umi_resp_in_ready   out  1   response input ready
//  umi_req_in_*        --   --  request input; same six signals/widths as umi_resp_in_*
//  umi_out_valid       out  1   merged output valid
//  umi_out_cmd/dstaddr/srcaddr/data  out  CW/AW/AW/DW  merged output payload
//  umi_out_ready       in   1   merged output ready
// BEHAVIOUR
//  - Handshake: beat transfers when valid&&ready on same edge; valid never depends on ready.
//  - Output stage: one-entry register; latency input-accept -> umi_out_valid = 1 cycle.
//    Slot accepts a new beat when empty or umi_out_ready=1 (full throughput, 1 beat/cycle).
//  - At most one input ready per cycle: ready = grant[i] && slot_can_accept.
//  - EOM = cmd[22]. FSM (umi_merger_arb): IDLE, LOCK_RESP, LOCK_REQ.
//    IDLE: pick among valid inputs; if both valid pick the one not granted last (rr_last);
//      grant applies combinationally same cycle. Accepted beat with EOM=1 stays IDLE and
//      updates rr_last; EOM=0 -> LOCK_<src>.
//    LOCK_x: only x granted, even if x idle and other valid; leave to IDLE on accepted beat
//      of x with EOM=1, updating rr_last=x.
//  - Reset: umi_out_valid=0, payload regs=0, both readies=0 during rst, FSM=IDLE,
//    rr_last=REQ (so response wins first tie). Reset mid-message drops the held beat and
//    the lock; no partial-message recovery.
//  - Back-pressure: umi_out_ready=0 with slot full -> both readies 0, payload held stable.
//  - Simultaneous: slot drain and refill same cycle permitted; resp/req both valid in IDLE
//    resolved purely by rr_last.
//  - No payload modification; cmd/addresses/data pass bit-exact.
// CONFIGURATION
//  UMI_MERGER_STATS_EN defined: adds out ports resp_msg_count[31:0], req_msg_count[31:0];
//    each increments by 1 on accepted beat with EOM=1 from that input, wraps 0xFFFF_FFFF->0,
//    cleared by rst. Undefined: ports and counters absent, behaviour otherwise identical.
// STRUCTURE
//  umi_merger_pkg: typedef enum logic [1:0] {IDLE, LOCK_RESP, LOCK_REQ} merge_state_t;
//    localparam UMI_EOM_BIT=22; typedef enum logic {SRC_RESP, SRC_REQ} merge_src_t.
//  Sub-module umi_merger_arb: FSM + rr_last, inputs valids/EOMs/accept, outputs grant[1:0].
//  Top: arbiter instance, payload mux, output register slot, optional stats counters.
// TESTING
//  1 Reset: hold rst 3 cycles with both inputs valid -> readies 0, umi_out_valid 0 throughout.
//  2 Single resp beat cmd EOM=1, data=0xA5.., out_ready=1 -> umi_out_valid next cycle, bit-exact.
//  3 Both inputs stream EOM=1 beats, out_ready=1 -> output alternates RESP,REQ,RESP,...
//    starting with RESP, 1 beat/cycle.
//  4 Req sends 4-beat message (EOM on beat 4) while resp valid -> 4 req beats contiguous,
//    then resp beat; no interleave.
//  5 out_ready random 50% over 1000 mixed messages -> scoreboard per-source order kept,
//    no loss/duplication, payload stable while valid&&!ready.
//  6 With UMI_MERGER_STATS_EN: 7 resp + 3 req messages -> resp_msg_count=7, req_msg_count=3;
//    rst clears both to 0.

Source files
------------

// File: rtl/umi_merger_pkg.sv
// umi_merger_pkg
//   Shared types and constants for the UMI merger: arbiter FSM state encoding,
//   source identifiers and the position of the end-of-message flag in the UMI
//   command word.
package umi_merger_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOCK_RESP = 2'd1,
        LOCK_REQ  = 2'd2
    } merge_state_t;

    typedef enum logic {
        SRC_RESP = 1'b0,
        SRC_REQ  = 1'b1
    } merge_src_t;

    localparam int UMI_EOM_BIT = 32'd22;

endpackage

// File: rtl/umi_merger_arb.sv
// umi_merger_arb
//   Message-granular round-robin arbiter between the response (index 0) and
//   request (index 1) inputs. A grant is held from the first beat of a message
//   until its EOM beat is accepted, so messages never interleave.
// Ports
//   clk, rst   : clock, synchronous active-high reset
//   valid_i[1:0]: input valids  {req, resp}
//   eom_i[1:0]  : EOM flag of the beat currently presented  {req, resp}
//   accept_i    : output slot can take a beat this cycle
//   grant_o[1:0]: one-hot (or zero) grant, combinational, same cycle
module umi_merger_arb
    import umi_merger_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid_i,
    input  logic [1:0] eom_i,
    input  logic       accept_i,
    output logic [1:0] grant_o
);

    merge_state_t state_q, state_d;
    merge_src_t   rr_last_q, rr_last_d;
    logic [1:0]   fire_s;

    // Grant selection: in IDLE a tie goes to the source not granted last.
    always_comb begin
        grant_o = 2'b00;
        case (state_q)
            IDLE: begin
                if (valid_i == 2'b11) begin
                    grant_o = (rr_last_q == SRC_REQ) ? 2'b01 : 2'b10;
                end else begin
                    grant_o = valid_i;
                end
            end
            LOCK_RESP: grant_o = 2'b01;
            LOCK_REQ:  grant_o = 2'b10;
            default:   grant_o = 2'b00;
        endcase
    end

    assign fire_s = grant_o & valid_i & {2{accept_i}};

    // Next-state: lock on a non-EOM beat, release (and record winner) on EOM.
    always_comb begin
        state_d   = state_q;
        rr_last_d = rr_last_q;
        case (state_q)
            IDLE: begin
                if (fire_s[0]) begin
                    if (eom_i[0]) begin
                        rr_last_d = SRC_RESP;
                    end else begin
                        state_d = LOCK_RESP;
                    end
                end else if (fire_s[1]) begin
                    if (eom_i[1]) begin
                        rr_last_d = SRC_REQ;
                    end else begin
                        state_d = LOCK_REQ;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            LOCK_RESP: begin
                if (fire_s[0] && eom_i[0]) begin
                    state_d   = IDLE;
                    rr_last_d = SRC_RESP;
                end else begin
                    state_d = LOCK_RESP;
                end
            end
            LOCK_REQ: begin
                if (fire_s[1] && eom_i[1]) begin
                    state_d   = IDLE;
                    rr_last_d = SRC_REQ;
                end else begin
                    state_d = LOCK_REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and round-robin history registers; REQ as last winner makes RESP win the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_last_q <= SRC_REQ;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
        end
    end

endmodule

// File: rtl/umi_merger.sv
// umi_merger
//   Merges a UMI response stream and a UMI request stream into one UMI output
//   stream through a one-entry output register (1 beat/cycle throughput,
//   1 cycle input-to-output latency). Payload passes bit-exact.
// Ports
//   clk, rst                          : clock, synchronous active-high reset
//   umi_resp_in_* / umi_req_in_*      : valid, cmd, dstaddr, srcaddr, data in; ready out
//   umi_out_*                         : valid, cmd, dstaddr, srcaddr, data out; ready in
//   resp_msg_count, req_msg_count     : completed-message counters (only with
//                                       UMI_MERGER_STATS_EN defined)
module umi_merger
    import umi_merger_pkg::*;
#(
    parameter int DW = 256,
    parameter int AW = 64,
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          umi_resp_in_valid,
    input  logic [CW-1:0] umi_resp_in_cmd,
    input  logic [AW-1:0] umi_resp_in_dstaddr,
    input  logic [AW-1:0] umi_resp_in_srcaddr,
    input  logic [DW-1:0] umi_resp_in_data,
    output logic          umi_resp_in_ready,
    input  logic          umi_req_in_valid,
    input  logic [CW-1:0] umi_req_in_cmd,
    input  logic [AW-1:0] umi_req_in_dstaddr,
    input  logic [AW-1:0] umi_req_in_srcaddr,
    input  logic [DW-1:0] umi_req_in_data,
    output logic          umi_req_in_ready,
    output logic          umi_out_valid,
    output logic [CW-1:0] umi_out_cmd,
    output logic [AW-1:0] umi_out_dstaddr,
    output logic [AW-1:0] umi_out_srcaddr,
    output logic [DW-1:0] umi_out_data,
    input  logic          umi_out_ready
`ifdef UMI_MERGER_STATS_EN
    ,
    output logic [31:0]   resp_msg_count,
    output logic [31:0]   req_msg_count
`endif
);

    logic [1:0]    grant_s;
    logic          can_accept_s;
    logic          accept_s;
    logic          fire_s;
    logic          out_valid_q;
    logic [CW-1:0] cmd_q, cmd_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [AW-1:0] src_q, src_d;
    logic [DW-1:0] data_q, data_d;

    // Slot takes a beat when empty or draining this cycle; readies held low in reset.
    assign can_accept_s = !out_valid_q || umi_out_ready;
    assign accept_s     = can_accept_s && !rst;

    umi_merger_arb u_arb (
        .clk      (clk),
        .rst      (rst),
        .valid_i  ({umi_req_in_valid, umi_resp_in_valid}),
        .eom_i    ({umi_req_in_cmd[UMI_EOM_BIT], umi_resp_in_cmd[UMI_EOM_BIT]}),
        .accept_i (accept_s),
        .grant_o  (grant_s)
    );

    assign umi_resp_in_ready = grant_s[0] && accept_s;
    assign umi_req_in_ready  = grant_s[1] && accept_s;
    assign fire_s = (umi_resp_in_valid && umi_resp_in_ready) ||
                    (umi_req_in_valid && umi_req_in_ready);

    // Payload mux driven by the grant.
    always_comb begin
        if (grant_s[1]) begin
            cmd_d  = umi_req_in_cmd;
            dst_d  = umi_req_in_dstaddr;
            src_d  = umi_req_in_srcaddr;
            data_d = umi_req_in_data;
        end else begin
            cmd_d  = umi_resp_in_cmd;
            dst_d  = umi_resp_in_dstaddr;
            src_d  = umi_resp_in_srcaddr;
            data_d = umi_resp_in_data;
        end
    end

    // Output slot: refill on accept, drain leaves payload untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            cmd_q       <= '0;
            dst_q       <= '0;
            src_q       <= '0;
            data_q      <= '0;
        end else if (can_accept_s) begin
            out_valid_q <= fire_s;
            if (fire_s) begin
                cmd_q  <= cmd_d;
                dst_q  <= dst_d;
                src_q  <= src_d;
                data_q <= data_d;
            end
        end
    end

    assign umi_out_valid   = out_valid_q;
    assign umi_out_cmd     = cmd_q;
    assign umi_out_dstaddr = dst_q;
    assign umi_out_srcaddr = src_q;
    assign umi_out_data    = data_q;

`ifdef UMI_MERGER_STATS_EN
    logic [31:0] resp_cnt_q;
    logic [31:0] req_cnt_q;

    // Count completed messages per input; wraps naturally at 32 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_cnt_q <= 32'd0;
            req_cnt_q  <= 32'd0;
        end else begin
            if (umi_resp_in_valid && umi_resp_in_ready && umi_resp_in_cmd[UMI_EOM_BIT]) begin
                resp_cnt_q <= resp_cnt_q + 32'd1;
            end
            if (umi_req_in_valid && umi_req_in_ready && umi_req_in_cmd[UMI_EOM_BIT]) begin
                req_cnt_q <= req_cnt_q + 32'd1;
            end
        end
    end

    assign resp_msg_count = resp_cnt_q;
    assign req_msg_count  = req_cnt_q;
`endif

endmodule

// File: tb/tb_umi_merger.sv
// tb_umi_merger
//   Randomized scoreboard bench for umi_merger. Drivers push every issued beat
//   into a per-source expected queue; a monitor pops on each output transfer.
//   The source of an output beat is tagged in srcaddr[AW-1].
//   Stats checks are built only when UMI_MERGER_STATS_EN is defined.
module tb_umi_merger;

    localparam int DW = 256;
    localparam int AW = 64;
    localparam int CW = 32;
    localparam int EOM = 22;

    typedef struct packed {
        logic [CW-1:0] cmd;
        logic [AW-1:0] dst;
        logic [AW-1:0] src;
        logic [DW-1:0] data;
    } beat_t;

    logic          clk;
    logic          rst;
    logic          in_valid [2];
    logic [CW-1:0] in_cmd   [2];
    logic [AW-1:0] in_dst   [2];
    logic [AW-1:0] in_src   [2];
    logic [DW-1:0] in_data  [2];
    logic          in_ready [2];
    logic          out_valid;
    logic [CW-1:0] out_cmd;
    logic [AW-1:0] out_dst;
    logic [AW-1:0] out_src;
    logic [DW-1:0] out_data;
    logic          out_ready;
`ifdef UMI_MERGER_STATS_EN
    logic [31:0]   resp_cnt;
    logic [31:0]   req_cnt;
`endif

    int    tests;
    int    fails;
    beat_t exp_resp[$];
    beat_t exp_req[$];
    int    log_src[$];
    int    log_cyc[$];

    umi_merger #(.DW(DW), .AW(AW), .CW(CW)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .umi_resp_in_valid   (in_valid[0]),
        .umi_resp_in_cmd     (in_cmd[0]),
        .umi_resp_in_dstaddr (in_dst[0]),
        .umi_resp_in_srcaddr (in_src[0]),
        .umi_resp_in_data    (in_data[0]),
        .umi_resp_in_ready   (in_ready[0]),
        .umi_req_in_valid    (in_valid[1]),
        .umi_req_in_cmd      (in_cmd[1]),
        .umi_req_in_dstaddr  (in_dst[1]),
        .umi_req_in_srcaddr  (in_src[1]),
        .umi_req_in_data     (in_data[1]),
        .umi_req_in_ready    (in_ready[1]),
        .umi_out_valid       (out_valid),
        .umi_out_cmd         (out_cmd),
        .umi_out_dstaddr     (out_dst),
        .umi_out_srcaddr     (out_src),
        .umi_out_data        (out_data),
        .umi_out_ready       (out_ready)
`ifdef UMI_MERGER_STATS_EN
        ,
        .resp_msg_count      (resp_cnt),
        .req_msg_count       (req_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    // Issue one message of nbeats beats from source s; a5 forces data to 0xA5 bytes.
    task automatic send_msg(input int s, input int nbeats, input bit a5);
        beat_t b;
        bit    hs;
        int    guard;
        for (int i = 0; i < nbeats; i++) begin
            b.cmd = $urandom();
            b.cmd[EOM] = (i == nbeats - 1);
            b.dst = {$urandom(), $urandom()};
            b.src = {$urandom(), $urandom()};
            b.src[AW-1] = s[0];
            for (int k = 0; k < DW / 32; k++) b.data[k*32 +: 32] = $urandom();
            if (a5) b.data = {(DW/8){8'hA5}};
            if (s == 0) exp_resp.push_back(b);
            else        exp_req.push_back(b);
            in_valid[s] = 1'b1;
            in_cmd[s]   = b.cmd;
            in_dst[s]   = b.dst;
            in_src[s]   = b.src;
            in_data[s]  = b.data;
            hs = 1'b0;
            guard = 0;
            while (!hs) begin
                @(negedge clk);
                hs = in_ready[s];
                @(posedge clk);
                #1;
                guard++;
                if (!hs && guard > 2000) begin
                    tests++;
                    fails++;
                    $display("FAIL handshake_timeout src%0d: got no ready required ready within 2000 cycles", s);
                    hs = 1'b1;
                end
            end
            in_valid[s] = 1'b0;
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Synchronous reset for 3 edges; optionally with both inputs valid.
    task automatic do_reset(input bit with_valid);
        rst = 1'b1;
        in_valid[0] = with_valid;
        in_valid[1] = with_valid;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("reset_resp_ready", 512'(in_ready[0]), 512'd0);
            check("reset_req_ready", 512'(in_ready[1]), 512'd0);
            check("reset_out_valid", 512'(out_valid), 512'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid[0] = 1'b0;
        in_valid[1] = 1'b0;
        exp_resp.delete();
        exp_req.delete();
        log_src.delete();
        log_cyc.delete();
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while ((exp_resp.size() != 0 || exp_req.size() != 0 || out_valid) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        check("drain_resp_queue_empty", 512'(exp_resp.size()), 512'd0);
        check("drain_req_queue_empty", 512'(exp_req.size()), 512'd0);
    endtask

    // Monitor: scoreboard pop, non-interleave and stall-stability checks.
    task automatic monitor();
        beat_t got, prev, e;
        bit    prev_stall;
        bit    last_eom;
        int    last_src;
        int    s;
        int    cyc;
        prev_stall = 1'b0;
        last_eom = 1'b1;
        last_src = 0;
        cyc = 0;
        prev = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                prev_stall = 1'b0;
                last_eom = 1'b1;
                continue;
            end
            got = {out_cmd, out_dst, out_src, out_data};
            if (prev_stall) begin
                check("stall_valid_held", 512'(out_valid), 512'd1);
                check("stall_payload_stable", 512'(got), 512'(prev));
            end
            if (out_valid && out_ready) begin
                s = int'(got.src[AW-1]);
                if (!last_eom) check("no_interleave_src", 512'(s), 512'(last_src));
                if ((s == 0 && exp_resp.size() == 0) || (s == 1 && exp_req.size() == 0)) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_beat src%0d: got %0h required nothing", s, got);
                end else begin
                    if (s == 0) e = exp_resp.pop_front();
                    else        e = exp_req.pop_front();
                    check("payload_order", 512'(got), 512'(e));
                end
                log_src.push_back(s);
                log_cyc.push_back(cyc);
                last_src = s;
                last_eom = got.cmd[EOM];
            end
            prev_stall = out_valid && !out_ready;
            prev = got;
        end
    endtask

    initial begin
        int ndone;
        tests = 0;
        fails = 0;
        rst = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid[i] = 1'b0;
            in_cmd[i] = '0;
            in_dst[i] = '0;
            in_src[i] = '0;
            in_data[i] = '0;
        end
        fork
            monitor();
        join_none

        // 1: reset with both inputs valid
        do_reset(1'b1);
        check("reset_out_cmd_zero", 512'(out_cmd), 512'd0);
        check("reset_out_data_zero", 512'(out_data), 512'd0);

        // 2: single response beat, one-cycle latency, bit-exact
        send_msg(0, 1, 1'b1);
        @(negedge clk);
        check("single_valid_next_cycle", 512'(out_valid), 512'd1);
        check("single_data_a5", 512'(out_data), 512'({(DW/8){8'hA5}}));
        @(negedge clk);
        check("single_valid_clears", 512'(out_valid), 512'd0);
        wait_drain();

        // 3: both stream EOM beats -> strict alternation starting with RESP
        do_reset(1'b0);
        fork
            for (int i = 0; i < 6; i++) send_msg(0, 1, 1'b0);
            for (int i = 0; i < 6; i++) send_msg(1, 1, 1'b0);
        join
        wait_drain();
        check("alt_count", 512'(log_src.size()), 512'd12);
        for (int i = 0; i < log_src.size(); i++) begin
            check("alt_src", 512'(log_src[i]), 512'(i % 2));
            check("alt_back_to_back", 512'(log_cyc[i]), 512'(log_cyc[0] + i));
        end

        // 4: 4-beat request message locks out a waiting response
        do_reset(1'b0);
        fork
            send_msg(1, 4, 1'b0);
            begin
                idle_cycles(1);
                send_msg(0, 1, 1'b0);
            end
        join
        wait_drain();
        check("lock_count", 512'(log_src.size()), 512'd5);
        for (int i = 0; i < log_src.size(); i++) begin
            check("lock_src", 512'(log_src[i]), 512'((i < 4) ? 1 : 0));
        end

        // 5: random traffic with random back-pressure
        do_reset(1'b0);
        ndone = 0;
        fork
            begin
                for (int m = 0; m < 500; m++) begin
                    idle_cycles($urandom_range(0, 2));
                    send_msg(0, $urandom_range(1, 4), 1'b0);
                end
                ndone++;
            end
            begin
                for (int m = 0; m < 500; m++) begin
                    idle_cycles($urandom_range(0, 2));
                    send_msg(1, $urandom_range(1, 4), 1'b0);
                end
                ndone++;
            end
            begin
                while (ndone < 2) begin
                    out_ready = 1'($urandom_range(0, 1));
                    idle_cycles(1);
                end
                out_ready = 1'b1;
            end
        join
        wait_drain();

`ifdef UMI_MERGER_STATS_EN
        // 6: message counters
        do_reset(1'b0);
        fork
            for (int i = 0; i < 7; i++) send_msg(0, $urandom_range(1, 3), 1'b0);
            for (int i = 0; i < 3; i++) send_msg(1, $urandom_range(1, 3), 1'b0);
        join
        wait_drain();
        check("stats_resp_count", 512'(resp_cnt), 512'd7);
        check("stats_req_count", 512'(req_cnt), 512'd3);
        do_reset(1'b0);
        check("stats_resp_cleared", 512'(resp_cnt), 512'd0);
        check("stats_req_cleared", 512'(req_cnt), 512'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
